// File: rtl/snes_pkg.sv
// Shared SNES pad definitions: button bit positions, frame layout and the
// responder state encoding. The SNES reader imports the same button indices.
package snes_pkg;

    // Button bit positions within a 12-bit button word (bit 0 is B).
    typedef enum int {
        BTN_B      = 0,
        BTN_Y      = 1,
        BTN_SELECT = 2,
        BTN_START  = 3,
        BTN_UP     = 4,
        BTN_DOWN   = 5,
        BTN_LEFT   = 6,
        BTN_RIGHT  = 7,
        BTN_A      = 8,
        BTN_X      = 9,
        BTN_L      = 10,
        BTN_R      = 11
    } snes_btn_e;

    localparam int         SNES_NUM_BUTTONS = 12;
    localparam int         SNES_FRAME_BITS  = 16;
    localparam logic [3:0] SNES_ID_BITS     = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        SHIFT,
        DONE
    } snes_state_t;

    // Active-low frame as it leaves the pad: ID bits on top, buttons LSB-first.
    function automatic logic [SNES_FRAME_BITS-1:0] snes_frame(
        input logic [SNES_NUM_BUTTONS-1:0] btn
    );
        return {SNES_ID_BITS, ~btn};
    endfunction

endpackage

// File: rtl/snes_pad_responder_if.sv
// Pad connector signals. The host (console or our reader) drives latch and
// shift clock; the pad answers on serial_data.
interface snes_pad_responder_if;

    logic data_latch;
    logic snes_clk;
    logic serial_data;

    modport master (
        output data_latch,
        output snes_clk,
        input  serial_data
    );

    modport slave (
        input  data_latch,
        input  snes_clk,
        output serial_data
    );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, followed by one extra
// flop so that single-cycle rise/fall pulses can be derived from the level.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT        = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Shift the raw input through the synchronizer and remember the last level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {SYNC_STAGES{INIT}};
            prev  <= INIT;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/snes_pad_responder.sv
// Emulated 12-button SNES pad. Answers the host's latch / shift-clock
// sequence with active-low serial button data, abandoning a frame if the
// host stops clocking for TIMEOUT cycles.
module snes_pad_responder
    import snes_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] TIMEOUT     = 16'd50000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    snes_pad_responder_if.slave         pad,
    input  logic [SNES_NUM_BUTTONS-1:0] buttons,
    output logic [SNES_NUM_BUTTONS-1:0] latched_buttons,
    output logic                        frame_done,
    output logic                        busy
);

    logic latch_s, latch_rise, latch_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic unused_edges;

    snes_state_t                state;
    logic [SNES_FRAME_BITS-1:0] sr;
    logic [4:0]                 bitcnt;
    logic [15:0]                tocnt;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .INIT        (1'b0)
    ) u_latch_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (pad.data_latch),
        .level   (latch_s),
        .rise    (latch_rise),
        .fall    (latch_fall)
    );

    // Shift clock idles high, so its synchronizer resets high to avoid a
    // spurious rise right after reset.
    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .INIT        (1'b1)
    ) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (pad.snes_clk),
        .level   (sclk_s),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    assign unused_edges = &{1'b0, latch_rise, sclk_s, sclk_fall};

    // Frame FSM: latch has priority over timeout, timeout over shift clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            sr              <= '1;
            bitcnt          <= '0;
            tocnt           <= '0;
            latched_buttons <= '0;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tocnt != TIMEOUT) begin
                tocnt <= tocnt + 16'd1;
            end

            if (latch_s) begin
                // Reload continuously while latch is high; last cycle wins.
                state  <= LATCH;
                busy   <= 1'b1;
                sr     <= snes_frame(buttons);
                bitcnt <= '0;
                if (state != LATCH) begin
                    tocnt <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        sr <= '1;
                    end
                    LATCH: begin
                        if (latch_fall) begin
                            state           <= SHIFT;
                            bitcnt          <= '0;
                            tocnt           <= '0;
                            latched_buttons <= buttons;
                        end
                    end
                    SHIFT, DONE: begin
                        if (tocnt == TIMEOUT) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            sr    <= '1;
                            tocnt <= '0;
                        end else if (sclk_rise) begin
                            tocnt <= '0;
                            // In DONE the line stays low and rises are ignored.
                            if (state == SHIFT) begin
                                sr     <= {1'b0, sr[SNES_FRAME_BITS-1:1]};
                                bitcnt <= bitcnt + 5'd1;
                                if (bitcnt == 5'(SNES_FRAME_BITS - 1)) begin
                                    state      <= DONE;
                                    frame_done <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        sr    <= '1;
                    end
                endcase
            end
        end
    end

    // Registered line driver: always presents the current LSB of the frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pad.serial_data <= 1'b1;
        end else begin
            pad.serial_data <= sr[0];
        end
    end

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench for snes_pad_responder: basic frame with latency, button
// patterns, abort by re-latch, timeout and asynchronous reset mid-frame.
module tb_snes_pad_responder;

    localparam int          SYNC_STAGES = 2;
    localparam logic [15:0] TIMEOUT     = 16'd100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] buttons;
    logic [11:0] latched_buttons;
    logic        frame_done;
    logic        busy;

    int n_cmp    = 0;
    int n_err    = 0;
    int fd_total = 0;
    int base;

    logic [15:0] bits;
    logic [11:0] pats [4] = '{12'hA5C, 12'hFFF, 12'h000, 12'h800};
    logic [15:0] exps [4] = '{16'hF5A3, 16'hF000, 16'hFFFF, 16'hF7FF};

    snes_pad_responder_if pad();

    snes_pad_responder #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pad             (pad),
        .buttons         (buttons),
        .latched_buttons (latched_buttons),
        .frame_done      (frame_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Count frame_done pulses; each pulse is one cycle wide.
    always @(negedge clk) begin
        if (frame_done) fd_total++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic latch(input int n);
        pad.data_latch = 1'b1;
        cyc(n);
        pad.data_latch = 1'b0;
        cyc(8);
    endtask

    // Host read: sample the line just before each falling edge, then pulse.
    task automatic shift(input int n, output logic [15:0] b);
        b = '0;
        for (int i = 0; i < n; i++) begin
            b[i] = pad.serial_data;
            pad.snes_clk = 1'b0;
            cyc(6);
            pad.snes_clk = 1'b1;
            cyc(6);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        buttons        = '0;
        pad.data_latch = 1'b0;
        pad.snes_clk   = 1'b1;
        cyc(3);
        chk("rst_serial", 32'(pad.serial_data), 32'h1);
        chk("rst_latched", 32'(latched_buttons), 32'h0);
        chk("rst_done", 32'(frame_done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        cyc(4);
        chk("idle_serial", 32'(pad.serial_data), 32'h1);

        // Basic frame: B pressed, B appears SYNC_STAGES+2 cycles after latch rise.
        base    = fd_total;
        buttons = 12'h001;
        pad.data_latch = 1'b1;
        cyc(3);
        chk("b_early", 32'(pad.serial_data), 32'h1);
        cyc(1);
        chk("b_bit_B", 32'(pad.serial_data), 32'h0);
        chk("b_busy_latch", 32'(busy), 32'h1);
        cyc(8);
        pad.data_latch = 1'b0;
        cyc(8);
        shift(16, bits);
        chk("b_bits", 32'(bits), 32'hFFFE);
        chk("b_latched", 32'(latched_buttons), 32'h001);
        cyc(8);
        chk("b_line_low", 32'(pad.serial_data), 32'h0);
        chk("b_busy_done", 32'(busy), 32'h1);
        chk("b_frame_done", 32'(fd_total - base), 32'h1);

        // Pattern frames; buttons change mid-frame and must not leak in.
        for (int p = 0; p < 4; p++) begin
            base    = fd_total;
            buttons = pats[p];
            latch(8);
            buttons = ~pats[p];
            shift(16, bits);
            chk($sformatf("pat%0d_bits", p), 32'(bits), 32'(exps[p]));
            chk($sformatf("pat%0d_latched", p), 32'(latched_buttons), 32'(pats[p]));
            cyc(8);
            chk($sformatf("pat%0d_low", p), 32'(pad.serial_data), 32'h0);
            pad.snes_clk = 1'b0;
            cyc(6);
            pad.snes_clk = 1'b1;
            cyc(14);
            chk($sformatf("pat%0d_stay_low", p), 32'(pad.serial_data), 32'h0);
            chk($sformatf("pat%0d_done", p), 32'(fd_total - base), 32'h1);
        end

        // Abort: re-latch after 5 shifts restarts from B with no done pulse.
        base    = fd_total;
        buttons = 12'h002;
        latch(8);
        shift(5, bits);
        chk("ab_first5", 32'(bits[4:0]), 32'h1D);
        buttons = 12'h001;
        latch(8);
        chk("ab_no_done", 32'(fd_total - base), 32'h0);
        chk("ab_busy", 32'(busy), 32'h1);
        shift(16, bits);
        chk("ab_bits", 32'(bits), 32'hFFFE);
        cyc(8);
        chk("ab_done", 32'(fd_total - base), 32'h1);

        // Timeout: clock stops after 7 shifts.
        base    = fd_total;
        buttons = 12'h001;
        latch(8);
        shift(7, bits);
        chk("to_bits", 32'(bits[6:0]), 32'h7E);
        cyc(40);
        chk("to_busy_wait", 32'(busy), 32'h1);
        cyc(100);
        chk("to_busy", 32'(busy), 32'h0);
        chk("to_serial", 32'(pad.serial_data), 32'h1);
        chk("to_no_done", 32'(fd_total - base), 32'h0);

        // Asynchronous reset in SHIFT with the line low.
        buttons = 12'hA5C;
        latch(8);
        shift(2, bits);
        chk("rm_pre_serial", 32'(pad.serial_data), 32'h0);
        chk("rm_pre_busy", 32'(busy), 32'h1);
        chk("rm_pre_latched", 32'(latched_buttons), 32'hA5C);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rm_serial", 32'(pad.serial_data), 32'h1);
        chk("rm_latched", 32'(latched_buttons), 32'h0);
        chk("rm_busy", 32'(busy), 32'h0);
        chk("rm_done", 32'(frame_done), 32'h0);
        cyc(2);
        reset_n = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snes_pad_responder.md
# snes_pad_responder

Controller-side end of the SNES pad serial link: emulates a standard 12-button SNES pad and answers the host's `data_latch` / `snes_clk` sequence with active-low serial button data on `serial_data`. It sits between on-board button sources (switches, soft inputs) and the pad connector. It lets another board, or our own SNES reader, poll this design as if it were a real controller. Host-side signals are asynchronous to `clk` and are synchronized internally.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in each input synchronizer. Minimum 2.
- `TIMEOUT`, default 16'd50000: `clk` cycles without a `snes_clk` rising edge in SHIFT or DONE before the block abandons the frame (1 ms at 50 MHz).

Ports:
- `clk`  in  1: system clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `data_latch`  in  1: host latch, asynchronous, active-high.
- `snes_clk`  in  1: host shift clock, asynchronous; idles high.
- `buttons`  in  12: active-high pressed state, bit order B, Y, SELECT, START, UP, DOWN, LEFT, RIGHT, A, X, L, R (bit 0 is B).
- `serial_data`  out  1: line to host; low means pressed; registered.
- `latched_buttons`  out  12: copy of `buttons` captured at latch fall; active-high.
- `frame_done`  out  1: one-cycle pulse after the 16th shift.
- `busy`  out  1: high when state is not IDLE.

## Operation
- **Synchronizers:** `data_latch` and `snes_clk` each pass through `SYNC_STAGES` flops to give `latch_s` and `sclk_s`. One further flop per signal provides edge detection: `latch_fall`, `sclk_rise`.
- **Shift register:** 16 bits, `sr`. Load value is {4'b1111, ~buttons}; bits 12–15 are the pad ID bits and read as unpressed. Each shift is `sr <= {1'b0, sr[15:1]}`. `serial_data <= sr[0]`, updated every cycle.
- **Bit counter:** 5 bits, `bitcnt`, range 0..16.
- **Timeout counter:** 16 bits, `tocnt`. Cleared on every `sclk_rise` and on every state change. Saturates at `TIMEOUT`.
- **States:**
  - IDLE: `sr` = all ones, so the line is high. `latch_s` = 1 → LATCH.
  - LATCH: `sr` reloads every cycle, so the last cycle of latch-high wins. `sclk_rise` is ignored. `latch_fall` → SHIFT, `bitcnt` = 0, `latched_buttons <= buttons`.
  - SHIFT: each `sclk_rise` shifts `sr` and increments `bitcnt`. On the rise that makes `bitcnt` = 16 → DONE and pulse `frame_done`. The line is now low, matching a real pad.
  - DONE: line held low. Further `sclk_rise` events are ignored.
- **Exits to IDLE:** `tocnt` reaching `TIMEOUT` in SHIFT or DONE → IDLE and reload `sr` to all ones. `latch_s` = 1 in any state → LATCH on the next cycle; this aborts an in-progress frame.
- **Priority:** reset > `latch_s` > timeout > `sclk_rise`.
- **Button changes:** changes to `buttons` during SHIFT do not affect the frame in flight.

## Timing
- **Reset values:** `serial_data` = 1, `latched_buttons` = 0, `frame_done` = 0, `busy` = 0, state IDLE, `sr` = 16'hFFFF, `bitcnt` = 0, `tocnt` = 0.
- **Latency:** a pin edge on `snes_clk` or `data_latch` reaches its detect pulse after `SYNC_STAGES`+1 cycles. `serial_data` changes one cycle after that, i.e. 4 cycles at the default.
- **B bit:** bit B is valid on the line `SYNC_STAGES`+2 cycles after latch rise. It stays valid until the first `snes_clk` rise after latch fall.
- **Sampling:** the host samples on the `snes_clk` falling edge, ≥6 µs after each rise. Requirement: `clk` ≥ 2 MHz so that data is stable at least 4 µs before sampling.
- **`frame_done`:** asserted in the cycle after the 16th `sclk_rise` detect, for exactly one cycle.
- **`busy`:** registered from the state.

## Structure
- Shared package `snes_pkg`: button index constants (B=0 … R=11), `SNES_FRAME_BITS` = 16, `SNES_ID_BITS` = 4'b1111, and the state enum {IDLE, LATCH, SHIFT, DONE}. Our SNES reader imports the same button indices.
- One sub-module, `sync_edge`: a parameterized synchronizer plus edge detector with outputs `level`, `rise`, `fall`. It is instantiated twice.

## Test plan
- **Basic frame:** reset, `buttons` = 12'h001 (B), latch pulse 12 µs, then 16 clock pulses of 6 µs → line reads 0 then 1×15. `latched_buttons` = 12'h001. One `frame_done`.
- **Full pattern:** `buttons` = 12'hA5C → the 16 sampled bits equal {4'b1111, ~12'hA5C} LSB-first. After the 16th rise the line goes low and stays low.
- **Closed loop:** drive this block with our SNES reader at 1.2 MHz → the reader's `button_data` equals `buttons` after two frames, for patterns 12'h000, 12'hFFF and walking-one.
- **Abort:** latch re-asserted after 5 shifts → reload. The frame restarts from B and no `frame_done` is emitted for the aborted frame.
- **Timeout:** stop `snes_clk` after 7 shifts → after `TIMEOUT` cycles `busy` = 0 and `serial_data` = 1.
- **Reset mid-frame:** assert `reset_n` low during SHIFT → all outputs return to their reset values immediately and asynchronously.
